// File: rtl/dlpf_coeff_reload_ctrl_if.sv
// Stream-side signals of the coefficient reload controller: the gated IQ
// handshake pair plus the coefficient reload port toward the filter.
interface dlpf_coeff_reload_ctrl_if #(
  parameter int unsigned COEFF_WIDTH = 16
);
  logic                   s_tvalid;
  logic                   s_tready;
  logic                   m_tvalid;
  logic                   m_tready;
  logic [COEFF_WIDTH-1:0] coeff_out;
  logic                   reload_tvalid;
  logic                   reload_tlast;
  logic                   reload_tready;

  modport master (
    input  s_tvalid, m_tready, reload_tready,
    output s_tready, m_tvalid, coeff_out, reload_tvalid, reload_tlast
  );

  modport slave (
    output s_tvalid, m_tready, reload_tready,
    input  s_tready, m_tvalid, coeff_out, reload_tvalid, reload_tlast
  );
endinterface

// File: rtl/dlpf_coeff_reload_ctrl.sv
// Run-time coefficient reload sequencer: shadow tap RAM, input gating while the
// filter drains, then an in-order tap stream with tlast on the final tap.
module dlpf_coeff_reload_ctrl #(
  parameter int unsigned COEFF_WIDTH  = 16,
  parameter int unsigned NUM_COEFFS   = 128,
  parameter int unsigned DRAIN_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          cfg_wr_en,
  input  logic [$clog2(NUM_COEFFS)-1:0] cfg_wr_addr,
  input  logic [COEFF_WIDTH-1:0]        cfg_wr_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          wr_err,
  dlpf_coeff_reload_ctrl_if.master      strm
);

  localparam int unsigned AW = $clog2(NUM_COEFFS);
  localparam int unsigned CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_COEFFS - 1);
  localparam logic [CW-1:0] DRAIN_INIT = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_LOAD,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [COEFF_WIDTH-1:0] coeff_q, coeff_d;
  logic                   rvalid_q, rvalid_d;
  logic                   rlast_q, rlast_d;
  logic                   gate_q, gate_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   wr_err_q, wr_err_d;

  logic                   ram_we;
  logic                   in_busy;
  logic                   fetch;
  logic                   finish;
  logic [COEFF_WIDTH-1:0] ram_q [NUM_COEFFS];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    coeff_d  = coeff_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    done_d   = 1'b0;
    wr_err_d = wr_err_q;
    ram_we   = 1'b0;
    fetch    = 1'b0;
    finish   = 1'b0;
    in_busy  = (state_q == S_DRAIN) || (state_q == S_LOAD);

    if (cfg_wr_en) begin
      if (in_busy) begin
        wr_err_d = 1'b1;
      end else begin
        ram_we = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_INIT;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_LOAD: begin
        // Registered RAM read doubles as the output register: a new tap is
        // fetched when the slot is empty or the current beat is accepted.
        finish = rvalid_q && strm.reload_tready && rlast_q;
        fetch  = !rvalid_q || (strm.reload_tready && !rlast_q);
        if (finish) begin
          state_d  = S_DONE;
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          done_d   = 1'b1;
        end else if (fetch) begin
          coeff_d  = ram_q[idx_q];
          rvalid_d = 1'b1;
          rlast_d  = (idx_q == LAST_IDX);
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Gate stays up through the DONE cycle so the filter sees the done pulse
    // before any new input beat.
    gate_d = (state_d != S_IDLE);
    busy_d = (state_d == S_DRAIN) || (state_d == S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      coeff_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      gate_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      coeff_q  <= coeff_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      gate_q   <= gate_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign wr_err             = wr_err_q;
  assign strm.coeff_out     = coeff_q;
  assign strm.reload_tvalid = rvalid_q;
  assign strm.reload_tlast  = rlast_q;
  assign strm.m_tvalid      = strm.s_tvalid & ~gate_q;
  assign strm.s_tready      = strm.m_tready & ~gate_q;

endmodule

// File: tb/tb_dlpf_coeff_reload_ctrl.sv
// Directed/randomized bench for dlpf_coeff_reload_ctrl against an array model
// of the shadow RAM and the expected in-order tap stream.
module tb_dlpf_coeff_reload_ctrl;

  localparam int NUM   = 128;
  localparam int DRAIN = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        cfg_wr_en;
  logic [6:0]  cfg_wr_addr;
  logic [15:0] cfg_wr_data;
  logic        start;
  logic        busy;
  logic        done;
  logic        wr_err;

  dlpf_coeff_reload_ctrl_if #(.COEFF_WIDTH(16)) bus ();

  dlpf_coeff_reload_ctrl #(
    .COEFF_WIDTH (16),
    .NUM_COEFFS  (NUM),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .wr_err     (wr_err),
    .strm       (bus.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] model_ram [NUM];
  logic [15:0] beats [$];
  logic        lasts [$];
  int cyc = 0;
  int ready_mode = 0;
  int done_cnt = 0;
  int done_cyc, last_beat_cyc, start_cyc;
  int gate_cnt, sgate_cnt, first_gate, last_gate;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_coeff;
  logic        prev_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rec_reset();
    beats.delete();
    lasts.delete();
    gate_cnt = 0; sgate_cnt = 0;
    first_gate = -1; last_gate = -1;
    done_cyc = -1; last_beat_cyc = -1;
  endtask

  // One clock: sample at negedge, then advance to just after the next posedge.
  task automatic tick();
    @(negedge clk);
    if (prev_stall) begin
      chk("hold_tvalid", bus.reload_tvalid, 1);
      chk("hold_coeff", bus.coeff_out, prev_coeff);
      chk("hold_tlast", bus.reload_tlast, prev_last);
    end
    prev_stall = bus.reload_tvalid && !bus.reload_tready && !reset && !clear;
    prev_coeff = bus.coeff_out;
    prev_last  = bus.reload_tlast;
    if (bus.reload_tvalid === 1'b1 && bus.reload_tready && !reset && !clear) begin
      beats.push_back(bus.coeff_out);
      lasts.push_back(bus.reload_tlast);
      last_beat_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.m_tvalid === 1'b0) begin
      gate_cnt++;
      if (first_gate < 0) first_gate = cyc;
      last_gate = cyc;
    end
    if (bus.s_tready === 1'b0) sgate_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0:       bus.reload_tready = 1'b1;
      1:       bus.reload_tready = ~bus.reload_tready;
      default: bus.reload_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic write_tap(input int a, input logic [15:0] d);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 7'(a);
    cfg_wr_data = d;
    tick();
    cfg_wr_en   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt - d0), 1);
    repeat (3) tick();
    chk({tag, "_one_done"}, 32'(done_cnt - d0), 1);
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_nbeats"}, beats.size(), NUM);
    for (int i = 0; i < beats.size() && i < NUM; i++) begin
      chk($sformatf("%s_beat%0d", tag, i), beats[i], model_ram[i]);
      chk($sformatf("%s_last%0d", tag, i), lasts[i], (i == NUM - 1));
    end
    chk({tag, "_done_lag"}, done_cyc, last_beat_cyc + 1);
  endtask

  task automatic begin_start(input int mode);
    rec_reset();
    ready_mode = mode;
    bus.reload_tready = 1'b1;
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int d0;
    int n;
    reset = 1'b1; clear = 1'b0; start = 1'b0;
    cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    bus.s_tvalid = 1'b1; bus.m_tready = 1'b1; bus.reload_tready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tvalid", bus.reload_tvalid, 0);
    chk("rst_tlast", bus.reload_tlast, 0);
    chk("rst_coeff", bus.coeff_out, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_m_tvalid", bus.m_tvalid, 1);
    chk("rst_s_tready", bus.s_tready, 1);
    bus.m_tready = 1'b0;
    #1 chk("pass_s_tready_low", bus.s_tready, 0);
    bus.m_tready = 1'b1;

    // Basic reload with ramp taps and the gate window
    for (int k = 0; k < NUM; k++) begin
      model_ram[k] = 16'h0100 + 16'(k);
      write_tap(k, model_ram[k]);
    end
    begin_start(0);
    chk("busy_after_start", busy, 1);
    wait_done("ramp");
    check_beats("ramp");
    chk("gate_first", first_gate, start_cyc + 1);
    chk("gate_last", last_gate, done_cyc);
    chk("gate_total", gate_cnt, DRAIN + 1 + NUM + 1);
    chk("sgate_total", sgate_cnt, DRAIN + 1 + NUM + 1);
    chk("idle_busy", busy, 0);

    // Backpressure 1010...
    begin_start(1);
    wait_done("toggle");
    check_beats("toggle");

    // Random taps, random backpressure
    for (int k = 0; k < NUM; k++) begin
      model_ram[k] = 16'($urandom);
      write_tap(k, model_ram[k]);
    end
    begin_start(2);
    wait_done("rand");
    check_beats("rand");

    // Write during LOAD is dropped and flagged
    begin_start(0);
    n = 0;
    while (bus.reload_tvalid !== 1'b1 && n < 1000) begin tick(); n++; end
    chk("wr5_reach_load", bus.reload_tvalid, 1);
    write_tap(5, 16'hBEEF);
    chk("wr5_err", wr_err, 1);
    wait_done("wr5_busy");
    check_beats("wr5_busy");
    chk("wr5_err_sticky", wr_err, 1);
    model_ram[5] = 16'hBEEF;
    write_tap(5, 16'hBEEF);
    begin_start(0);
    wait_done("wr5_idle");
    check_beats("wr5_idle");

    // Write and start in the same IDLE cycle
    rec_reset();
    ready_mode = 0;
    model_ram[0] = 16'h1234;
    cfg_wr_en = 1'b1; cfg_wr_addr = 7'd0; cfg_wr_data = 16'h1234;
    start = 1'b1;
    tick();
    cfg_wr_en = 1'b0; start = 1'b0;
    wait_done("wr_start");
    check_beats("wr_start");

    // Second start during DRAIN is ignored
    d0 = done_cnt;
    begin_start(0);
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("restart");
    repeat (400) tick();
    chk("restart_done_count", 32'(done_cnt - d0), 1);
    check_beats("restart");

    // Clear mid-DRAIN aborts but keeps wr_err
    d0 = done_cnt;
    begin_start(0);
    repeat (50) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_tvalid", bus.reload_tvalid, 0);
    chk("clr_gate", bus.m_tvalid, 1);
    chk("clr_wr_err", wr_err, 1);
    repeat (450) tick();
    chk("clr_no_done", 32'(done_cnt - d0), 0);
    chk("clr_no_beats", beats.size(), 0);

    // Reset at beat 40 of LOAD
    d0 = done_cnt;
    begin_start(0);
    n = 0;
    while (beats.size() < 40 && n < 1000) begin tick(); n++; end
    chk("rst40_reach", beats.size(), 40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst40_tvalid", bus.reload_tvalid, 0);
    chk("rst40_busy", busy, 0);
    chk("rst40_gate", bus.m_tvalid, 1);
    chk("rst40_wr_err", wr_err, 0);
    repeat (300) tick();
    chk("rst40_no_done", 32'(done_cnt - d0), 0);
    chk("rst40_partial", beats.size(), 40);
    begin_start(0);
    wait_done("rst40_again");
    check_beats("rst40_again");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
